// File: rtl/soc_pio_pkg.sv
// Shared constants for the edge-capturing PIO input slave.
// Register word offsets and edge-type selectors.
package soc_pio_pkg;

  localparam logic [1:0] PIO_DATA    = 2'd0;
  localparam logic [1:0] PIO_RSVD    = 2'd1;
  localparam logic [1:0] PIO_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_EDGECAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pio_sync.sv
// Multi-stage synchroniser for an asynchronous input bus.
// Ports: clk, reset_n (async low), d (async in), q (synced out).
module pio_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] stg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stg <= '0;
    end else begin
      stg <= {stg[STAGES-2:0], d};
    end
  end

  assign q = stg[STAGES-1];

endmodule

// File: rtl/soc_system_pio_in_edge.sv
// Avalon-MM input PIO with sticky edge capture and maskable irq.
// Ports: clk, reset_n, address/chipselect/write_n/writedata/readdata, in_port, irq.
module soc_system_pio_in_edge
  import soc_pio_pkg::*;
#(
  parameter int          WIDTH       = 8,
  parameter int          SYNC_STAGES = 2,
  parameter int          EDGE_TYPE   = 0,
  parameter logic [31:0] RESET_MASK  = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int ARM_MAX = SYNC_STAGES + 1;
  localparam int CW      = $clog2(SYNC_STAGES + 2);
  localparam logic [CW-1:0] ARM_TOP = CW'(ARM_MAX);

  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] ec_clr;
  logic [WIDTH-1:0] ec_nxt;
  logic [CW-1:0]    arm_cnt;
  logic             armed;
  logic             wr;
  logic             wr_mask;
  logic             wr_ec;
  logic [31:0]      rd_mux;

  pio_sync #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (in_port),
    .q       (sync)
  );

  // prev only holds real history once the chain has filled,
  // so edges stay suppressed until the counter saturates.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev    <= '0;
      arm_cnt <= '0;
    end else begin
      prev <= sync;
      if (arm_cnt != ARM_TOP) begin
        arm_cnt <= arm_cnt + 1'b1;
      end
    end
  end

  assign armed = (arm_cnt == ARM_TOP);

  always_comb begin
    edge_det = sync & ~prev;
    if (EDGE_TYPE == EDGE_FALL) begin
      edge_det = ~sync & prev;
    end else if (EDGE_TYPE == EDGE_ANY) begin
      edge_det = sync ^ prev;
    end
  end

  assign edge_hit = armed ? edge_det : '0;

  assign wr      = chipselect & ~write_n;
  assign wr_mask = wr && (address == PIO_IRQMASK);
  assign wr_ec   = wr && (address == PIO_EDGECAP);
  assign ec_clr  = wr_ec ? writedata[WIDTH-1:0] : '0;
  // A fresh edge overrides a clear of the same bit.
  assign ec_nxt  = (edgecap & ~ec_clr) | edge_hit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask <= RESET_MASK[WIDTH-1:0];
      edgecap <= '0;
    end else begin
      edgecap <= ec_nxt;
      if (wr_mask) begin
        irqmask <= writedata[WIDTH-1:0];
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    unique case (address)
      PIO_DATA:    rd_mux[WIDTH-1:0] = sync;
      PIO_RSVD:    rd_mux = '0;
      PIO_IRQMASK: rd_mux[WIDTH-1:0] = irqmask;
      PIO_EDGECAP: rd_mux[WIDTH-1:0] = edgecap;
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      readdata <= rd_mux;
      irq      <= |(edgecap & irqmask);
    end
  end

endmodule

// File: tb/tb_soc_system_pio_in_edge.sv
// Directed bench: rising-edge and any-edge instances on a shared bus.
// Read expectations queue on issue and are checked on readdata return.
module tb_soc_system_pio_in_edge;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [31:0] rd_r;
  logic [31:0] rd_a;
  logic        irq_r;
  logic        irq_a;

  int n_chk;
  int n_err;
  logic [31:0] exp_q[$];

  soc_system_pio_in_edge #(
    .WIDTH       (8),
    .SYNC_STAGES (2),
    .EDGE_TYPE   (0),
    .RESET_MASK  (32'h0)
  ) u_rise (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (rd_r),
    .irq        (irq_r)
  );

  soc_system_pio_in_edge #(
    .WIDTH       (8),
    .SYNC_STAGES (2),
    .EDGE_TYPE   (2),
    .RESET_MASK  (32'h0)
  ) u_any (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (rd_a),
    .irq        (irq_a)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_irq(input string tag, input logic er,
                         input logic ea);
    chk({tag, "_irq_rise"}, {31'b0, irq_r}, {31'b0, er});
    chk({tag, "_irq_any"}, {31'b0, irq_a}, {31'b0, ea});
  endtask

  // Called at a negedge; returns at the next negedge.
  task automatic rd(input logic [1:0] a, input logic [31:0] er,
                    input logic [31:0] ea, input string tag);
    exp_q.push_back(er);
    exp_q.push_back(ea);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    @(negedge clk);
    chk({tag, "_rise"}, rd_r, exp_q.pop_front());
    chk({tag, "_any"}, rd_a, exp_q.pop_front());
    chipselect = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    n_chk      = 0;
    n_err      = 0;
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 8'hA5;
    idle(2);
    chk("rst_rd_rise", rd_r, 32'h0);
    chk("rst_rd_any", rd_a, 32'h0);
    chk_irq("rst", 1'b0, 1'b0);

    // input held high through release: no edges
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk_irq("arm", 1'b0, 1'b0);
    end
    rd(2'd0, 32'hA5, 32'hA5, "data_a5");
    rd(2'd3, 32'h0, 32'h0, "ec_arm");
    rd(2'd1, 32'h0, 32'h0, "rsvd");
    rd(2'd2, 32'h0, 32'h0, "mask_rst");

    // rising edge bit0, latency and W1C
    wr(2'd2, 32'h1);
    in_port = 8'hA4;
    idle(4);
    wr(2'd3, 32'hFF);
    idle(1);
    rd(2'd3, 32'h0, 32'h0, "ec_pre");
    chk_irq("pre", 1'b0, 1'b0);
    in_port = 8'hA5;
    idle(2);
    chk_irq("k1", 1'b0, 1'b0);
    idle(1);
    chk_irq("k2", 1'b0, 1'b0);
    rd(2'd3, 32'h1, 32'h1, "ec_k2");
    chk_irq("k3", 1'b1, 1'b1);
    wr(2'd3, 32'h1);
    chk_irq("clr0", 1'b1, 1'b1);
    rd(2'd3, 32'h0, 32'h0, "ec_clr");
    chk_irq("clr1", 1'b0, 1'b0);

    // falling edge bit0: only the any-edge instance sees it
    in_port = 8'hA4;
    idle(4);
    rd(2'd3, 32'h0, 32'h1, "ec_fall");
    chk_irq("fall", 1'b0, 1'b1);
    wr(2'd3, 32'hFF);
    idle(1);

    // bit3 pulse with mask 0, then unmask
    wr(2'd2, 32'h0);
    in_port = 8'hAC;
    idle(3);
    in_port = 8'hA4;
    idle(4);
    rd(2'd3, 32'h8, 32'h8, "ec_b3");
    chk_irq("b3_masked", 1'b0, 1'b0);
    wr(2'd2, 32'h8);
    chk_irq("unmask0", 1'b0, 1'b0);
    idle(1);
    chk_irq("unmask1", 1'b1, 1'b1);
    wr(2'd3, 32'hFF);
    wr(2'd2, 32'h0);
    idle(1);

    // clear colliding with a new edge on bit4
    in_port = 8'hB4;
    idle(4);
    in_port = 8'hA4;
    idle(4);
    rd(2'd3, 32'h10, 32'h10, "ec_b4");
    in_port = 8'hB4;
    idle(2);
    wr(2'd3, 32'h10);
    rd(2'd3, 32'h10, 32'h10, "ec_collide");
    wr(2'd3, 32'h10);
    rd(2'd3, 32'h0, 32'h0, "ec_b4_clr");

    // mask width, read-only and reserved offsets
    wr(2'd2, 32'hFFFF_FFFF);
    rd(2'd2, 32'hFF, 32'hFF, "mask_ff");
    wr(2'd0, 32'h1234_5678);
    wr(2'd1, 32'hFFFF_FFFF);
    rd(2'd0, 32'hB4, 32'hB4, "data_ro");
    rd(2'd1, 32'h0, 32'h0, "rsvd_wr");
    chk_irq("idle_ff", 1'b0, 1'b0);

    // reset mid-operation with pending captures
    in_port = 8'hB7;
    idle(4);
    rd(2'd3, 32'h3, 32'h3, "ec_03");
    idle(1);
    chk_irq("pre_rst", 1'b1, 1'b1);
    chk("pre_rst_rd_rise", rd_r, 32'h3);
    #2;
    reset_n = 1'b0;
    #1;
    chk_irq("async_rst", 1'b0, 1'b0);
    chk("async_rd_rise", rd_r, 32'h0);
    chk("async_rd_any", rd_a, 32'h0);
    in_port = 8'h4B;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_irq("rearm", 1'b0, 1'b0);
    end
    rd(2'd2, 32'h0, 32'h0, "mask_rearm");
    rd(2'd3, 32'h0, 32'h0, "ec_rearm");
    rd(2'd0, 32'h4B, 32'h4B, "data_rearm");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/soc_system_pio_in_edge.md
Name: soc_system_pio_in_edge

Overview:
Parametrised Avalon-MM slave that captures a WIDTH-bit general-purpose input bus for the HPS.
- Synchronises the input bus into clk.
- Detects per-bit edges, latches them in a sticky edge-capture register and raises a maskable level interrupt.
- Successor to the single-bit, data-only input ports on the soc_system fabric (button, switch and screen-status lines). Instantiated once per input group under Qsys.

Parameters:
WIDTH, 8, number of input bits (1..32); readdata bits above WIDTH-1 read 0
SYNC_STAGES, 2, synchroniser flop depth (2..4)
EDGE_TYPE, 0, 0 = rising, 1 = falling, 2 = any edge
RESET_MASK, 0, reset value of irqmask[WIDTH-1:0]

Ports:
clk  in  1  system clock; all flops rising-edge
reset_n  in  1  asynchronous, active-low reset
address  in  2  register word offset
chipselect  in  1  slave select
write_n  in  1  active-low write strobe, valid only with chipselect=1
writedata  in  32  write data
in_port  in  WIDTH  asynchronous external inputs
readdata  out  32  registered read data
irq  out  1  level interrupt, active high

Behaviour:
- Reset (reset_n=0, asynchronous): every flop is cleared, including readdata=0, irq=0, synchroniser stages=0, prev=0, edgecapture=0 and the arm counter=0; irqmask=RESET_MASK.
- Synchroniser: in_port passes through SYNC_STAGES flops; sync is the last stage. prev is sync delayed by one clk.
- Edge detect (combinational, per bit):
  - rising: sync & ~prev
  - falling: ~sync & prev
  - any: sync ^ prev
- Arm: a counter runs from 0 to SYNC_STAGES+1 after reset and saturates there. Edge detect is gated off until the counter saturates, so an input held high or low through reset release never produces an edge.
- Register map (word offsets):
  - 0 DATA, read-only: {0, sync}. Writes are ignored.
  - 1 reserved: reads 0; writes ignored.
  - 2 IRQMASK, R/W, bits [WIDTH-1:0].
  - 3 EDGECAPTURE, R/W1C: a bit is set by a detected edge and cleared by writing 1 to it; writing 0 has no effect.
- Write: takes effect at the clk edge where chipselect=1 and write_n=0.
- Read: readdata is updated every clk from the address mux. Read latency is 1 cycle, and readdata reflects register contents as they stood before that edge.
- irq = |(edgecapture & irqmask), driven from a flop. irq rises 1 clk after the edgecapture or irqmask update that enables it, and falls 1 clk after the clearing write.
- Latency: an input transition sampled at edge k is visible in DATA at edge k+SYNC_STAGES-1, sets edgecapture at edge k+SYNC_STAGES and asserts irq at edge k+SYNC_STAGES+1.
- Simultaneous W1C clear and new edge on the same bit in the same cycle: the set wins and the bit stays 1. Other bits clear normally.
- Repeated edges while a bit is already set: the bit stays 1. There is no count and no overflow.
- Writes to IRQMASK bits at or above WIDTH are discarded; those bits read 0.
- Reset mid-operation: everything returns immediately to reset values. Any pending capture is lost, and irq drops asynchronously with reset.
- A narrow input pulse shorter than one clk may be missed. This is acceptable and documented.

Decomposition:
- Shared package soc_pio_pkg:
  - Register offset constants: PIO_DATA=0, PIO_IRQMASK=2, PIO_EDGECAP=3.
  - Edge-type constants: EDGE_RISE=0, EDGE_FALL=1, EDGE_ANY=2.
- One sub-module, pio_sync: a WIDTH-wide, SYNC_STAGES-deep synchroniser with asynchronous reset to 0, instantiated once.

Test Plan:
- Reset then hold in_port=8'hA5 from time 0 -> after arming, DATA reads 0x000000A5, EDGECAPTURE reads 0, irq=0 throughout.
- EDGE_TYPE=0, irqmask=0x01, in_port bit0 0->1 sampled at edge k -> edgecapture[0]=1 at k+2 and irq=1 at k+3. Write 0x01 to offset 3 -> edgecapture=0 and irq=0 one clk later.
- EDGE_TYPE=2, irqmask=0, toggle bit3 high then low -> edgecapture=0x08 and irq stays 0. Then write irqmask=0x08 -> irq=1 one clk after the write.
- W1C write of 0x10 in the same cycle a new rising edge is detected on bit4 -> edgecapture[4] remains 1. Writing 0x10 without a new edge clears it.
- Write 0xFFFFFFFF to IRQMASK with WIDTH=8 -> readback 0x000000FF. Write to DATA and to offset 1 -> DATA unchanged; offset 1 reads 0.
- Assert reset_n=0 mid-cycle while irq=1 and edgecapture=0x03 -> irq and readdata drop immediately, irqmask returns to RESET_MASK, and no edge is captured for SYNC_STAGES+1 clks after release.
